// File: rtl/stream_scoreboard_if.sv
// ---------------------------------------------------------------------------
// stream_scoreboard_if
// Groups the stimulus-side expected stream and the DUT result stream that
// feed stream_scoreboard. Compared words are {flags, data} with the flags
// in the MSBs.
//   exp_valid/exp_ready/exp_data : expected-word push handshake
//   exp_last                     : stimulus exhausted (level)
//   cmp_mask                     : 1 = bit compared, sampled with each result
//   act_valid/act_data           : DUT result, no backpressure
// Modports: master = bench/stimulus side, slave = scoreboard.
// ---------------------------------------------------------------------------
interface stream_scoreboard_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int FLAGS_WIDTH = 4
);
   localparam int W = FLAGS_WIDTH + DATA_WIDTH;

   logic         exp_valid;
   logic         exp_ready;
   logic [W-1:0] exp_data;
   logic         exp_last;
   logic [W-1:0] cmp_mask;
   logic         act_valid;
   logic [W-1:0] act_data;

   modport master (
      output exp_valid, exp_data, exp_last, cmp_mask, act_valid, act_data,
      input  exp_ready
   );

   modport slave (
      input  exp_valid, exp_data, exp_last, cmp_mask, act_valid, act_data,
      output exp_ready
   );
endinterface

// File: rtl/stream_scoreboard.sv
// ---------------------------------------------------------------------------
// stream_scoreboard
// In-order result checker. Expected words are buffered in a DEPTH-entry
// FIFO; each DUT result pops the head and is compared under cmp_mask.
// Results arriving with nothing buffered (or after the run finished) are
// counted as unexpected.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   sb (slave)      : expected stream, mask and DUT result stream
//   match_count     : matched results, saturating
//   mismatch_count  : mismatched + unexpected results, saturating
//   done            : run finished (terminal until reset)
//   error           : sticky failure flag
//
// Optional feature: define SCOREBOARD_TIMEOUT_EN to add a watchdog that
// ends the run with error when no result arrives for TIMEOUT cycles while
// expected words are pending.
//
// state | meaning
// IDLE  | waiting for the first expected word
// RUN   | expected words being accepted, results checked
// DRAIN | stimulus exhausted, waiting for the FIFO to empty
// DONE  | run finished, terminal until reset
// ---------------------------------------------------------------------------
module stream_scoreboard #(
   parameter int DATA_WIDTH  = 8,
   parameter int FLAGS_WIDTH = 4,
   parameter int DEPTH       = 16,
   parameter int TIMEOUT     = 256,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   stream_scoreboard_if.slave      sb,
   output logic [COUNT_WIDTH-1:0]  match_count,
   output logic [COUNT_WIDTH-1:0]  mismatch_count,
   output logic                    done,
   output logic                    error
);
   localparam int W  = FLAGS_WIDTH + DATA_WIDTH;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("stream_scoreboard: DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("stream_scoreboard: TIMEOUT must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state;
   state_t         state_nxt;

   logic [W-1:0]   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    occ;
   logic           last_seen;

   logic           fifo_empty;
   logic           fifo_full;
   logic           push_req;
   logic           push_en;
   logic           drain_push;
   logic           pop_en;
   logic           unexpected;
   logic           cmp_ok;
   logic           bad_result;
   logic           timeout_hit;

   assign fifo_empty   = (occ == '0);
   assign fifo_full    = (occ == (AW+1)'(DEPTH));
   assign sb.exp_ready = !fifo_full;

   assign push_req   = sb.exp_valid & sb.exp_ready;
   // Words offered once the stimulus claimed to be finished are dropped and
   // flagged rather than silently extending the run.
   assign push_en    = push_req & ((state == IDLE) | (state == RUN));
   assign drain_push = push_req & (state == DRAIN);

   // A same-cycle push is not yet visible as head, so it cannot be popped.
   assign pop_en     = sb.act_valid & !fifo_empty & (state != DONE);
   assign unexpected = sb.act_valid & !pop_en;
   assign cmp_ok     = (((sb.act_data ^ mem[rd_ptr]) & sb.cmp_mask) == '0);
   assign bad_result = (pop_en & !cmp_ok) | unexpected;

   assign done = (state == DONE);

`ifdef SCOREBOARD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0]  wd_cnt;
   logic           wd_armed;
   logic           wd_count;

   assign wd_armed    = ((state == RUN) | (state == DRAIN)) & !sb.act_valid;
   assign wd_count    = wd_armed & !fifo_empty;
   assign timeout_hit = wd_count & (wd_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if (!wd_armed) begin
         wd_cnt <= '0;
      end else if (wd_count && !timeout_hit) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // FIFO storage carries no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wr_ptr] <= sb.exp_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_en && !pop_en) begin
            occ <= occ + 1'b1;
         end else if (pop_en && !push_en) begin
            occ <= occ - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_count    <= '0;
         mismatch_count <= '0;
         error          <= 1'b0;
         last_seen      <= 1'b0;
      end else begin
         if (pop_en && cmp_ok && (match_count != '1)) begin
            match_count <= match_count + 1'b1;
         end
         if (bad_result && (mismatch_count != '1)) begin
            mismatch_count <= mismatch_count + 1'b1;
         end
         if (bad_result || drain_push || timeout_hit) begin
            error <= 1'b1;
         end
         if (sb.exp_last) begin
            last_seen <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (push_en) begin
               state_nxt = RUN;
            end else if ((sb.exp_last || last_seen) && fifo_empty) begin
               state_nxt = DONE;
            end
         end
         RUN: begin
            if (last_seen) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = DONE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (timeout_hit) begin
         state_nxt = DONE;
      end
   end
endmodule
